// File: rtl/hc08_tester.sv
// hc08_tester: drives an 8-vector sequence into a quad 2-input AND gate.
// It samples Y through a 2-flop synchroniser and reports a pass/fail result for each gate.
module hc08_tester #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] A_o,
    output logic [3:0] B_o,
    input  logic [3:0] Y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] first_fail,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_k;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    logic [3:0] w_exp;
    logic [3:0] w_miss;
    logic [3:0] w_mask_nxt;
    logic [2:0] w_k_nxt;

    // Odd gates (1 and 3) see the complemented combination on vectors 4..7.
    function automatic logic [3:0] vec_a(input logic [2:0] k);
        vec_a = {4{k[1]}} ^ ({4{k[2]}} & 4'b1010);
    endfunction

    function automatic logic [3:0] vec_b(input logic [2:0] k);
        vec_b = {4{k[0]}} ^ ({4{k[2]}} & 4'b1010);
    endfunction

    assign w_exp      = A_o & B_o;
    assign w_miss     = r_sync2 ^ w_exp;
    assign w_mask_nxt = fail_mask | w_miss;
    assign w_k_nxt    = r_k + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_k        <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            A_o        <= '0;
            B_o        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else begin
            r_sync1 <= Y_i;
            r_sync2 <= r_sync1;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_APPLY;
                        r_k        <= '0;
                        r_cnt      <= '0;
                        A_o        <= vec_a(3'd0);
                        B_o        <= vec_b(3'd0);
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_mask  <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (r_cnt == LP_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    fail_mask <= w_mask_nxt;
                    if ((w_miss != 4'd0) && !fail_valid) begin
                        first_fail <= r_k;
                        fail_valid <= 1'b1;
                    end
                    if (r_k == 3'd7) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_mask_nxt == 4'd0);
                        A_o     <= '0;
                        B_o     <= '0;
                    end else begin
                        r_state <= S_APPLY;
                        r_k     <= w_k_nxt;
                        r_cnt   <= '0;
                        A_o     <= vec_a(w_k_nxt);
                        B_o     <= vec_b(w_k_nxt);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
